// File: rtl/note_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : note_sequencer_if                                               |
// | Purpose  : Event bus between the melody sequencer and the voice stage.     |
// |            One event per note boundary: note-on (gate=1) or space.        |
// | Signals  : ev_valid  seq->voice  event available                           |
// |            ev_ready  voice->seq  event accepted on this edge               |
// |            ev_gate   seq->voice  1 = note-on, 0 = silence                  |
// |            ev_inc    seq->voice  phase increment per sample (0 on space)   |
// |            ev_index  seq->voice  melody index the event belongs to         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface note_sequencer_if;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_gate;
    logic [6:0] ev_inc;
    logic [4:0] ev_index;

    modport master (
        output ev_valid,
        output ev_gate,
        output ev_inc,
        output ev_index,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_gate,
        input  ev_inc,
        input  ev_index,
        output ev_ready
    );
endinterface
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : note_sequencer                                                  |
// | Purpose  : Steps through the 25-entry Nyan melody ROM at a tick tempo and  |
// |            issues one note-on or space event per note boundary over a      |
// |            valid/ready handshake.                                          |
// | Ports    : clk        sole clock, rising edge                              |
// |            rst        synchronous active-high reset                        |
// |            enable     1 = durations count, 0 = durations frozen            |
// |            restart    one-cycle request to restart the melody at index 0   |
// |            ev         event bus (master side)                              |
// |            loop_done  one-cycle pulse when the index wraps to 0            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module note_sequencer #(
    parameter int TICK_CYCLES = 699904,
    parameter int SHORT_TICKS = 3,
    parameter int LONG_TICKS  = 7,
    parameter int SPACE_TICKS = 1,
    parameter int MELODY_LEN  = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             restart,
    note_sequencer_if.master ev,
    output logic             loop_done
);

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_ISSUE_NOTE  = 3'd1;
    localparam logic [2:0] c_NOTE        = 3'd2;
    localparam logic [2:0] c_ISSUE_SPACE = 3'd3;
    localparam logic [2:0] c_SPACE       = 3'd4;

    localparam logic [19:0] c_TICK_LAST   = 20'(TICK_CYCLES - 1);
    localparam logic [2:0]  c_SHORT_LAST  = 3'(SHORT_TICKS - 1);
    localparam logic [2:0]  c_LONG_LAST   = 3'(LONG_TICKS - 1);
    localparam logic [2:0]  c_SPACE_LAST  = 3'(SPACE_TICKS - 1);
    localparam logic [4:0]  c_LAST_INDEX  = 5'(MELODY_LEN - 1);

    // Phase increments per pitch
    localparam logic [6:0] c_GS = 7'd67;
    localparam logic [6:0] c_FS = 7'd60;
    localparam logic [6:0] c_DS = 7'd50;
    localparam logic [6:0] c_D  = 7'd48;
    localparam logic [6:0] c_CS = 7'd45;
    localparam logic [6:0] c_B  = 7'd40;

    logic [2:0]  r_state;
    logic [19:0] r_tick;
    logic [2:0]  r_beat;
    logic [4:0]  r_index;
    logic        r_loop_done;

    logic [6:0]  w_pitch;
    logic        w_long;
    logic [2:0]  w_beat_last;
    logic        w_tick_last;
    logic        w_period_done;

    // Melody ROM: pitch and long/short flag for the current index
    always_comb begin
        w_pitch = 7'd0;
        w_long  = 1'b0;
        case (r_index)
            5'd0:  begin w_pitch = c_FS; w_long = 1'b1; end
            5'd1:  begin w_pitch = c_GS; w_long = 1'b1; end
            5'd2:  w_pitch = c_D;
            5'd3:  begin w_pitch = c_DS; w_long = 1'b1; end
            5'd4:  w_pitch = c_B;
            5'd5:  w_pitch = c_D;
            5'd6:  w_pitch = c_CS;
            5'd7:  begin w_pitch = c_B;  w_long = 1'b1; end
            5'd8:  begin w_pitch = c_B;  w_long = 1'b1; end
            5'd9:  begin w_pitch = c_CS; w_long = 1'b1; end
            5'd10: begin w_pitch = c_D;  w_long = 1'b1; end
            5'd11: w_pitch = c_D;
            5'd12: w_pitch = c_CS;
            5'd13: w_pitch = c_B;
            5'd14: w_pitch = c_CS;
            5'd15: w_pitch = c_DS;
            5'd16: w_pitch = c_FS;
            5'd17: w_pitch = c_GS;
            5'd18: w_pitch = c_DS;
            5'd19: w_pitch = c_FS;
            5'd20: w_pitch = c_CS;
            5'd21: w_pitch = c_D;
            5'd22: w_pitch = c_B;
            5'd23: w_pitch = c_CS;
            5'd24: w_pitch = c_B;
            default: ;
        endcase
    end

    // Beat count at which the current NOTE or SPACE period ends
    always_comb begin
        if (r_state == c_NOTE) begin
            w_beat_last = w_long ? c_LONG_LAST : c_SHORT_LAST;
        end else begin
            w_beat_last = c_SPACE_LAST;
        end
    end

    assign w_tick_last   = (r_tick == c_TICK_LAST);
    assign w_period_done = w_tick_last && (r_beat == w_beat_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_tick      <= '0;
            r_beat      <= '0;
            r_index     <= '0;
            r_loop_done <= 1'b0;
        end else begin
            r_loop_done <= 1'b0;
            if (restart) begin
                // Overrides everything, including a handshake on this edge
                r_state <= c_ISSUE_NOTE;
                r_index <= '0;
                r_tick  <= '0;
                r_beat  <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (enable) r_state <= c_ISSUE_NOTE;
                    end
                    // ev_valid is high in both ISSUE states, so ev_ready alone
                    // marks the handshake; durations count from acceptance.
                    c_ISSUE_NOTE: begin
                        if (ev.ev_ready) begin
                            r_state <= c_NOTE;
                            r_tick  <= '0;
                            r_beat  <= '0;
                        end
                    end
                    c_ISSUE_SPACE: begin
                        if (ev.ev_ready) begin
                            r_state <= c_SPACE;
                            r_tick  <= '0;
                            r_beat  <= '0;
                        end
                    end
                    c_NOTE, c_SPACE: begin
                        if (enable) begin
                            if (w_period_done) begin
                                r_tick <= '0;
                                r_beat <= '0;
                                if (r_state == c_NOTE) begin
                                    r_state <= c_ISSUE_SPACE;
                                end else begin
                                    r_state <= c_ISSUE_NOTE;
                                    if (r_index == c_LAST_INDEX) begin
                                        r_index     <= '0;
                                        r_loop_done <= 1'b1;
                                    end else begin
                                        r_index <= r_index + 5'd1;
                                    end
                                end
                            end else if (w_tick_last) begin
                                r_tick <= '0;
                                r_beat <= r_beat + 3'd1;
                            end else begin
                                r_tick <= r_tick + 20'd1;
                            end
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    // Payload is decoded from registered state and index only
    assign ev.ev_valid = (r_state == c_ISSUE_NOTE) || (r_state == c_ISSUE_SPACE);
    assign ev.ev_gate  = (r_state == c_ISSUE_NOTE);
    assign ev.ev_inc   = (r_state == c_ISSUE_NOTE) ? w_pitch : 7'd0;
    assign ev.ev_index = r_index;
    assign loop_done   = r_loop_done;

endmodule
`default_nettype wire
